// File: rtl/bist_pkg.sv
// Shared definitions for the BIST chain: controller states, default MISR
// parameters and the CUT response width used by every BIST block.
package bist_pkg;

    // Width of one CUT response word: {sum, cout}.
    localparam int RESP_W = 2;

    // Default signature register configuration.
    localparam int         SIG_W_DEF        = 8;
    localparam logic [7:0] POLY_DEF         = 8'h1D;
    localparam logic [7:0] SEED_DEF         = 8'h00;
    localparam int         NUM_PATTERNS_DEF = 8;

    // Response analyzer controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bist_resp_analyzer_if.sv
// Test-control and response bus of the response analyzer. The master side is
// the BIST sequencer / CUT; the slave side is the analyzer itself.
interface bist_resp_analyzer_if #(
    parameter int SIG_W = 8,
    parameter int CW    = 4
);
    import bist_pkg::*;

    logic              start;
    logic              resp_valid;
    logic [RESP_W-1:0] resp_data;
    logic [SIG_W-1:0]  golden_sig;
    logic              busy;
    logic              done;
    logic              pass;
    logic [SIG_W-1:0]  signature;
    logic [CW-1:0]     count;

    modport master (
        output start, resp_valid, resp_data, golden_sig,
        input  busy, done, pass, signature, count
    );

    modport slave (
        input  start, resp_valid, resp_data, golden_sig,
        output busy, done, pass, signature, count
    );

endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register. Galois-style shift with polynomial
// feedback from the outgoing MSB; the response word is XORed into the low bits.
module bist_misr
    import bist_pkg::*;
#(
    parameter int               SIG_W = SIG_W_DEF,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift_en,
    input  logic [RESP_W-1:0] data,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] feedback;
    logic [SIG_W-1:0] next_sig;

    // Next MISR value: shift left, fold the dropped MSB back through POLY,
    // then compact the incoming response into the low bits.
    always_comb begin
        // NOTE: every combinational output is assigned on every path, so no latch is inferred.
        feedback = sig[SIG_W-1] ? POLY : '0;
        next_sig = {sig[SIG_W-2:0], 1'b0} ^ feedback ^ {{(SIG_W-RESP_W){1'b0}}, data};
    end

    // Signature register: seed on reset or load, advance on an accepted response.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignment so all registers sample pre-edge values.
        if (!rst_n) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (shift_en) begin
            sig <= next_sig;
        end
    end

endmodule

// File: rtl/bist_resp_analyzer.sv
// BIST output response analyzer. Compacts NUM_PATTERNS CUT responses into a
// MISR, then compares the final signature with a golden value and reports
// pass/fail via a start/done handshake. Controller, response counter and
// comparator live here; the signature register is the bist_misr sub-module.
module bist_resp_analyzer
    import bist_pkg::*;
#(
    parameter int               SIG_W        = SIG_W_DEF,
    parameter logic [SIG_W-1:0] POLY         = SIG_W'(POLY_DEF),
    parameter logic [SIG_W-1:0] SEED         = SIG_W'(SEED_DEF),
    parameter int               NUM_PATTERNS = NUM_PATTERNS_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    bist_resp_analyzer_if.slave bus
);

    localparam int            CW   = $clog2(NUM_PATTERNS + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);

    state_e           state;
    state_e           next_state;
    logic             load;
    logic             shift_en;
    logic             last_resp;
    logic [CW-1:0]    count_q;
    logic             pass_q;
    logic [SIG_W-1:0] sig;

    // Decode handshake events: a start only counts in IDLE/DONE (and then
    // wins over any coincident response); responses only count in RUN.
    always_comb begin
        load      = bus.start && ((state == IDLE) || (state == DONE));
        shift_en  = (state == RUN) && bus.resp_valid;
        last_resp = shift_en && (count_q == LAST);
    end

    // Controller next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load)      next_state = RUN;
            RUN:     if (last_resp) next_state = CHECK;
            CHECK:                  next_state = DONE;
            DONE:    if (load)      next_state = RUN;
            default:                next_state = IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Accepted-response counter; stops at NUM_PATTERNS because RUN is left
    // on the edge that accepts the last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (shift_en) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Registered verdict: cleared on a new test, captured during CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 1'b0;
        end else if (load) begin
            pass_q <= 1'b0;
        end else if (state == CHECK) begin
            pass_q <= (sig == bus.golden_sig);
        end
    end

    bist_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .shift_en (shift_en),
        .data     (bus.resp_data),
        .sig      (sig)
    );

    assign bus.busy      = (state == RUN) || (state == CHECK);
    assign bus.done      = (state == DONE);
    assign bus.pass      = pass_q;
    assign bus.signature = sig;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_bist_resp_analyzer.sv
// Scoreboard bench for bist_resp_analyzer. The driver computes expected MISR
// values with a GF(2) polynomial model and queues them; a monitor compares
// them whenever the DUT advances its count or raises done.
module tb_bist_resp_analyzer;
    import bist_pkg::*;

    localparam int         SIG_W = 8;
    localparam int         NP    = 8;
    localparam int         CW    = $clog2(NP + 1);
    localparam logic [7:0] POLY  = 8'h1D;
    localparam logic [7:0] SEED  = 8'h00;

    typedef logic [1:0] resp_arr_t [NP];
    typedef int         gap_arr_t  [NP];
    typedef struct { logic [7:0] sig; int cnt; } step_t;
    typedef struct { logic [7:0] sig; logic pass; int done_cyc; } result_t;

    logic    clk    = 1'b0;
    logic    rst_n  = 1'b1;
    int      cyc    = 0;
    int      checks = 0;
    int      errors = 0;
    step_t   sig_q[$];
    result_t res_q[$];

    bist_resp_analyzer_if #(.SIG_W(SIG_W), .CW(CW)) bus ();

    bist_resp_analyzer #(
        .SIG_W        (SIG_W),
        .POLY         (POLY),
        .SEED         (SEED),
        .NUM_PATTERNS (NP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Signature as a polynomial over GF(2): s(x)*x mod (x^8 + POLY) + d(x).
    function automatic logic [7:0] misr_model(input logic [7:0] s, input logic [1:0] d);
        logic [8:0] t;
        t = {s, 1'b0};
        if (t[8]) t = t ^ {1'b1, POLY};
        return t[7:0] ^ {6'b0, d};
    endfunction

    function automatic logic [7:0] final_sig(input resp_arr_t d);
        logic [7:0] s;
        s = SEED;
        for (int k = 0; k < NP; k++) s = misr_model(s, d[k]);
        return s;
    endfunction

    // Monitor: compare on every count advance and on every done rise.
    logic [CW-1:0] prev_count = '0;
    logic          prev_done  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_count = '0;
            prev_done  = 1'b0;
        end else begin
            if (bus.count !== prev_count && bus.count != '0) begin
                if (sig_q.size() == 0) begin
                    check("unexpected_count_step", 32'(bus.count), 32'(prev_count));
                end else begin
                    step_t e;
                    e = sig_q.pop_front();
                    check("step_count", 32'(bus.count), 32'(e.cnt));
                    check("step_signature", 32'(bus.signature), 32'(e.sig));
                end
            end
            if (bus.done === 1'b1 && !prev_done) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 32'(0));
                end else begin
                    result_t r;
                    r = res_q.pop_front();
                    check("done_latency", 32'(cyc), 32'(r.done_cyc));
                    check("final_signature", 32'(bus.signature), 32'(r.sig));
                    check("final_pass", 32'(bus.pass), 32'(r.pass));
                    check("final_count", 32'(bus.count), 32'(NP));
                end
            end
            prev_count = bus.count;
            prev_done  = bus.done;
        end
    end

    // One full test: queue expectations, start, feed responses with gaps.
    task automatic run_test(input resp_arr_t d, input gap_arr_t g,
                            input logic [7:0] golden, input int pulse_at);
        logic [7:0] s;
        int         total;
        step_t      e;
        result_t    r;
        s     = SEED;
        total = NP + 2;
        for (int k = 0; k < NP; k++) begin
            s     = misr_model(s, d[k]);
            e.sig = s;
            e.cnt = k + 1;
            sig_q.push_back(e);
            total += g[k];
        end
        @(negedge clk);
        bus.start      = 1'b1;
        bus.golden_sig = golden;
        bus.resp_valid = 1'($urandom_range(0, 1));
        bus.resp_data  = 2'($urandom_range(0, 3));
        r.sig      = s;
        r.pass     = (s == golden);
        r.done_cyc = cyc + total;
        res_q.push_back(r);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.resp_valid = 1'b0;
        check("load_busy", 32'(bus.busy), 32'(1));
        check("load_done", 32'(bus.done), 32'(0));
        check("load_count", 32'(bus.count), 32'(0));
        check("load_signature", 32'(bus.signature), 32'(SEED));
        for (int k = 0; k < NP; k++) begin
            for (int j = 0; j < g[k]; j++) begin
                bus.resp_valid = 1'b0;
                bus.resp_data  = 2'($urandom_range(0, 3));
                @(negedge clk);
            end
            bus.resp_valid = 1'b1;
            bus.resp_data  = d[k];
            bus.start      = (k == pulse_at);
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.resp_valid = 1'b0;
        for (int w = 0; w < 4 && bus.done !== 1'b1; w++) @(negedge clk);
        check("done_reached", 32'(bus.done), 32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resp_arr_t ones;
        resp_arr_t zeros;
        resp_arr_t bad;
        resp_arr_t rnd;
        gap_arr_t  nogap;
        gap_arr_t  alt;
        gap_arr_t  rgap;
        logic [7:0] s;
        logic [7:0] golden;
        step_t      e;

        ones  = '{default: 2'b11};
        zeros = '{default: 2'b00};
        bad   = ones;
        bad[4] = 2'b10;
        nogap = '{default: 0};
        alt   = '{0, 1, 1, 1, 1, 1, 1, 1};

        bus.start      = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = 2'b00;
        bus.golden_sig = 8'h00;

        // Asynchronous reset between edges.
        #12 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_pass", 32'(bus.pass), 32'(0));
        check("rst_signature", 32'(bus.signature), 32'(SEED));
        check("rst_count", 32'(bus.count), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Fault-free all-ones, continuous valid.
        run_test(ones, nogap, 8'h1C, -1);
        // cout stuck-at-0 on the fifth response.
        run_test(bad, nogap, 8'h1C, -1);
        // All-zero responses with a gap between every response.
        run_test(zeros, alt, 8'h00, -1);
        // start pulsed mid-RUN is ignored.
        run_test(ones, nogap, 8'h1C, 3);

        // Responses offered in DONE are ignored.
        bus.resp_valid = 1'b1;
        bus.resp_data  = 2'b11;
        repeat (2) @(negedge clk);
        bus.resp_valid = 1'b0;
        check("done_hold_done", 32'(bus.done), 32'(1));
        check("done_hold_count", 32'(bus.count), 32'(NP));
        check("done_hold_signature", 32'(bus.signature), 32'(8'h1C));

        // Reset after four accepted responses.
        s = SEED;
        for (int k = 0; k < 4; k++) begin
            s     = misr_model(s, 2'b01);
            e.sig = s;
            e.cnt = k + 1;
            sig_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = 2'b01;
            @(negedge clk);
        end
        bus.resp_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("partial_steps_seen", 32'(sig_q.size()), 32'(0));
        check("midrst_busy", 32'(bus.busy), 32'(0));
        check("midrst_done", 32'(bus.done), 32'(0));
        check("midrst_pass", 32'(bus.pass), 32'(0));
        check("midrst_signature", 32'(bus.signature), 32'(SEED));
        check("midrst_count", 32'(bus.count), 32'(0));
        sig_q.delete();
        res_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_test(ones, nogap, 8'h1C, -1);

        // Randomized tests with random gaps and matching/non-matching goldens.
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < NP; k++) begin
                rnd[k]  = 2'($urandom_range(0, 3));
                rgap[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
            end
            golden = final_sig(rnd);
            if ($urandom_range(0, 1) == 1) golden = golden ^ (8'h01 << $urandom_range(0, 7));
            run_test(rnd, rgap, golden, -1);
        end

        @(negedge clk);
        check("steps_drained", 32'(sig_q.size()), 32'(0));
        check("results_drained", 32'(res_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_resp_analyzer.md
Name: bist_resp_analyzer

Overview:
Output response analyzer stage of the BIST chain; sits directly downstream of the circuit under test and consumes its 2-bit {sum,cout} response each test cycle. It compacts a fixed-length stream of responses into a multiple-input signature register (MISR). At end of test it compares the final signature against a golden value and reports pass/fail through a start/done handshake.

Parameters:
SIG_W, 8, MISR width in bits; legal range 4..32.
POLY, 8'h1D, Galois feedback polynomial; bit 0 must be 1; width SIG_W.
SEED, 8'h00, MISR value loaded on start; width SIG_W.
NUM_PATTERNS, 8, number of responses compacted per test; legal range >= 1.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a test; honoured only in IDLE or DONE.
resp_valid  input  1  a CUT response is present on resp_data this cycle.
resp_data  input  2  CUT response {sum,cout}; bit1=sum, bit0=cout.
golden_sig  input  SIG_W  expected signature; sampled in CHECK; must be stable from start to done.
busy  output  1  high in RUN and CHECK.
done  output  1  high in DONE; held until the next accepted start.
pass  output  1  registered compare result; meaningful only while done=1.
signature  output  SIG_W  current MISR contents.
count  output  CW  accepted responses this test; CW = $clog2(NUM_PATTERNS+1).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; signature=SEED; count=0; busy=0; done=0; pass=0.
- States: IDLE, RUN, CHECK, DONE.
- IDLE: start=1 -> load signature=SEED, count=0, pass=0, go RUN.
- DONE: done=1; start=1 -> same as IDLE start (done drops the same edge), go RUN.
- RUN: on each edge with resp_valid=1: signature <= ({sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0)) ^ {zeros, resp_data}; count <= count+1.
  resp_valid=0 -> signature and count hold (gaps allowed, no timeout).
  When the accepted response makes count == NUM_PATTERNS, go CHECK on that same edge.
- CHECK: exactly one cycle; pass <= (signature == golden_sig); go DONE.
- Latency: done rises one edge after the edge accepting the last response. With continuous resp_valid, done is high 10 edges after start (1 load + 8 samples + 1 check) for NUM_PATTERNS=8.
- resp_valid in IDLE, CHECK or DONE: ignored; signature, count unchanged.
- start in RUN or CHECK: ignored; test proceeds.
- Simultaneous start and resp_valid in IDLE/DONE: start wins; the response is not compacted.
- count never exceeds NUM_PATTERNS; no wrap.
- Reset mid-test: immediate return to reset values; no partial result is retained.
- MISR arithmetic is XOR-only, fixed width SIG_W; the shifted-out MSB feeds back via POLY.

Decomposition:
- Shared package bist_pkg: state enum (IDLE, RUN, CHECK, DONE), default SIG_W, POLY and SEED constants, and a response-width constant RESP_W=2 also used by the pattern generator and CUT wrapper.
- One sub-module, bist_misr: parameters SIG_W, POLY, SEED; inputs clk, rst_n, load, shift_en, data[1:0]; output sig.
- Controller FSM, counter and comparator stay in bist_resp_analyzer.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> busy=0, done=0, pass=0, signature=8'h00, count=0 with no clock edge.
- Fault-free all-ones: start, then 8 consecutive resp_valid with resp_data=2'b11 and golden_sig=8'h1C. Required intermediate signatures are 03,05,09,11,21,41,81,1C. done=1 and pass=1 on the 10th edge after start.
- Mismatch: same stimulus, but the 5th response is 2'b10 (cout stuck-at-0 case) and golden_sig=8'h1C -> final signature differs from 8'h1C and pass=0 at done.
- Gapped valid: 8 responses of 2'b00 with resp_valid low every other cycle and golden_sig=8'h00. Signature holds during gaps; count reaches 8; pass=1; done arrives 17 edges after start.
- Ignored controls: start pulsed while in RUN, and resp_valid=1 in DONE -> count and signature unchanged by these events, done stays 1. A subsequent start clears done, reloads signature=8'h00 and sets count=0.
- Reset mid-test: rst_n low after 4 accepted responses -> all outputs return to reset values. A new start yields a full 8-response test with the correct pass result.
